instr_sequencer: RTL and testbench

- Multi-cycle control FSM that fetches one instruction at a time from instruction memory and holds it stable for the combinational instruction decoder.
- Turns the decoder's RegWrite and PrintValue levels into timed strobes: a one-cycle register-file write pulse and a valid/ready print handshake.
- Owns the program counter, jump redirect, run/stop control and a retired-instruction counter.
- Sits between instruction memory and the decode/register-file/ALU datapath.

---
 rtl/instr_sequencer_pkg.sv | 18 +
 rtl/instr_sequencer_pc_unit.sv | 48 ++++
 rtl/instr_sequencer.sv | 129 ++++++++++++
 tb/tb_instr_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared constants and the sequencer state encoding for the instruction
// fetch/decode/execute control path.
package instr_sequencer_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPTYPE_W = 3;
    localparam int PC_W     = 8;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        e_SEQ_IDLE   = 3'd0,
        e_SEQ_FETCH  = 3'd1,
        e_SEQ_DECODE = 3'd2,
        e_SEQ_EXEC   = 3'd3,
        e_SEQ_PRINT  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/instr_sequencer_pc_unit.sv
// Program counter with increment/jump selection and a held next-pc that lets
// a print instruction defer its pc update until the print handshake.
module instr_sequencer_pc_unit #(
    parameter int PC_W = instr_sequencer_pkg::PC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture,
    input  logic            load_now,
    input  logic            load_saved,
    input  logic            jump_taken,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] npc_q, npc_d;
    logic [PC_W-1:0] next_pc;

    // Increment wraps naturally at PC_W bits (0xFF + 1 -> 0x00 for PC_W = 8).
    assign next_pc = jump_taken ? jump_target : pc_q + PC_W'(1);

    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (capture) begin
            npc_d = next_pc;
        end
        if (load_now) begin
            pc_d = next_pc;
        end else if (load_saved) begin
            pc_d = npc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            npc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches one instruction, holds it for the
// decoder, and turns decoder levels into register-write and print strobes.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_W  = instr_sequencer_pkg::INSTR_W,
    parameter int PC_W     = instr_sequencer_pkg::PC_W,
    parameter int CNT_W    = instr_sequencer_pkg::CNT_W,
    parameter int OPTYPE_W = instr_sequencer_pkg::OPTYPE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_q,
    input  logic               dec_reg_write,
    input  logic               dec_print,
    input  logic               jump_taken,
    input  logic [PC_W-1:0]    jump_target,
    output logic               rf_we,
    output logic               print_valid,
    input  logic               print_ready,
    output logic               busy,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   retired
);

    seq_state_e                     state_q, state_d;
    logic [OPTYPE_W-1:0]            optype_q, optype_d;
    logic [INSTR_W-OPTYPE_W-1:0]    body_q, body_d;
    logic [CNT_W-1:0]               retired_q, retired_d;
    logic                           imem_req_q, rf_we_q, print_valid_q, busy_q;
    logic                           pc_capture, pc_load_now, pc_load_saved;

    always_comb begin
        state_d       = state_q;
        optype_d      = optype_q;
        body_d        = body_q;
        retired_d     = retired_q;
        pc_capture    = 1'b0;
        pc_load_now   = 1'b0;
        pc_load_saved = 1'b0;
        case (state_q)
            e_SEQ_IDLE: begin
                if (run) begin
                    state_d = e_SEQ_FETCH;
                end
            end
            e_SEQ_FETCH: begin
                if (imem_valid) begin
                    {body_d, optype_d} = imem_data;
                    state_d            = e_SEQ_DECODE;
                end
            end
            e_SEQ_DECODE: begin
                state_d = e_SEQ_EXEC;
            end
            e_SEQ_EXEC: begin
                // The redirect decision is frozen here even when the pc update waits for PRINT.
                pc_capture = 1'b1;
                if (dec_print) begin
                    state_d = e_SEQ_PRINT;
                end else begin
                    pc_load_now = 1'b1;
                    retired_d   = retired_q + CNT_W'(1);
                    state_d     = run ? e_SEQ_FETCH : e_SEQ_IDLE;
                end
            end
            e_SEQ_PRINT: begin
                if (print_ready) begin
                    pc_load_saved = 1'b1;
                    retired_d     = retired_q + CNT_W'(1);
                    state_d       = run ? e_SEQ_FETCH : e_SEQ_IDLE;
                end
            end
            default: begin
                state_d = e_SEQ_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= e_SEQ_IDLE;
            optype_q      <= '0;
            body_q        <= '0;
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            rf_we_q       <= 1'b0;
            print_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            optype_q      <= optype_d;
            body_q        <= body_d;
            retired_q     <= retired_d;
            imem_req_q    <= (state_d == e_SEQ_FETCH);
            rf_we_q       <= (state_d == e_SEQ_EXEC) && dec_reg_write;
            print_valid_q <= (state_d == e_SEQ_PRINT);
            busy_q        <= (state_d != e_SEQ_IDLE);
        end
    end

    instr_sequencer_pc_unit #(
        .PC_W(PC_W)
    ) u_pc_unit (
        .clk        (clk),
        .reset      (reset),
        .capture    (pc_capture),
        .load_now   (pc_load_now),
        .load_saved (pc_load_saved),
        .jump_taken (jump_taken),
        .jump_target(jump_target),
        .pc         (pc)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc;
    assign instr_q     = {body_q, optype_q};
    assign rf_we       = rf_we_q;
    assign print_valid = print_valid_q;
    assign busy        = busy_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: the bench plays instruction memory,
// decoder, datapath and print consumer.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = '0;
    logic [15:0] instr_q;
    logic        dec_reg_write = 1'b0;
    logic        dec_print = 1'b0;
    logic        jump_taken = 1'b0;
    logic [7:0]  jump_target = '0;
    logic        rf_we;
    logic        print_valid;
    logic        print_ready = 1'b0;
    logic        busy;
    logic [7:0]  pc;
    logic [15:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .INSTR_W(16), .PC_W(8), .CNT_W(16), .OPTYPE_W(3)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .instr_q(instr_q), .dec_reg_write(dec_reg_write), .dec_print(dec_print),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .rf_we(rf_we), .print_valid(print_valid), .print_ready(print_ready),
        .busy(busy), .pc(pc), .retired(retired)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs a non-print instruction starting from a FETCH cycle; leaves the bench one cycle after EXEC.
    task automatic exec_instr(input logic [15:0] data, input logic regw, input logic jt,
                              input logic [7:0] tgt, input logic keep_run);
        imem_valid = 1'b1; imem_data = data; dec_reg_write = regw; dec_print = 1'b0;
        step();
        imem_valid = 1'b0; run = keep_run;
        step();
        jump_taken = jt; jump_target = tgt;
        step();
        jump_taken = 1'b0; jump_target = '0; dec_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
        n_checks++; if (retired !== 16'h0) begin n_fail++; $display("FAIL reset_retired: got %h want 0000", retired); end
        n_checks++; if (instr_q !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", instr_q); end
        n_checks++; if ({imem_req, rf_we, print_valid, busy} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {imem_req, rf_we, print_valid, busy}); end
        reset = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_rtype();
        run = 1'b1;
        step();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 8'h00})
            begin n_fail++; $display("FAIL rtype_fetch: got req=%b addr=%h want req=1 addr=00", imem_req, imem_addr); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rtype_busy: got %b want 1", busy); end
        imem_valid = 1'b1; imem_data = 16'h1234; dec_reg_write = 1'b1;
        step();
        imem_valid = 1'b0; run = 1'b0;
        n_checks++; if (instr_q !== 16'h1234) begin n_fail++; $display("FAIL rtype_instr: got %h want 1234", instr_q); end
        n_checks++; if ({imem_req, rf_we} !== 2'b00)
            begin n_fail++; $display("FAIL rtype_decode: got req=%b we=%b want 0 0", imem_req, rf_we); end
        step();
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL rtype_we_exec: got %b want 1", rf_we); end
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL rtype_pc_exec: got %h want 00", pc); end
        step();
        dec_reg_write = 1'b0;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rtype_we_after: got %b want 0", rf_we); end
        n_checks++; if ({pc, retired} !== {8'h01, 16'd1})
            begin n_fail++; $display("FAIL rtype_done: got pc=%h ret=%0d want pc=01 ret=1", pc, retired); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rtype_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_print();
        int hi_cnt = 0;
        int we_cnt = 0;
        run = 1'b1;
        step();
        n_checks++; if (imem_addr !== 8'h01) begin n_fail++; $display("FAIL print_addr: got %h want 01", imem_addr); end
        imem_valid = 1'b1; imem_data = 16'h0005; dec_print = 1'b1;
        step();
        imem_valid = 1'b0; run = 1'b0; print_ready = 1'b1;
        step();
        n_checks++; if ({rf_we, print_valid} !== 2'b00)
            begin n_fail++; $display("FAIL print_exec: got we=%b pv=%b want 0 0", rf_we, print_valid); end
        step();
        print_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (print_valid === 1'b1) hi_cnt++;
            if (rf_we === 1'b1) we_cnt++;
            n_checks++; if ({pc, retired} !== {8'h01, 16'd1})
                begin n_fail++; $display("FAIL print_hold_%0d: got pc=%h ret=%0d want pc=01 ret=1", i, pc, retired); end
            step();
        end
        if (print_valid === 1'b1) hi_cnt++;
        print_ready = 1'b1;
        step();
        print_ready = 1'b0; dec_print = 1'b0;
        n_checks++; if (hi_cnt !== 6) begin n_fail++; $display("FAIL print_valid_cycles: got %0d want 6", hi_cnt); end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL print_rf_we: got %0d cycles want 0", we_cnt); end
        n_checks++; if ({pc, retired, print_valid} !== {8'h02, 16'd2, 1'b0})
            begin n_fail++; $display("FAIL print_done: got pc=%h ret=%0d pv=%b want pc=02 ret=2 pv=0", pc, retired, print_valid); end
    endtask

    task automatic test_jump();
        run = 1'b1;
        step();
        exec_instr(16'h1111, 1'b0, 1'b1, 8'h10, 1'b1);
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 8'h10})
            begin n_fail++; $display("FAIL jump_to_10: got req=%b addr=%h want 1 10", imem_req, imem_addr); end
        exec_instr(16'h2222, 1'b0, 1'b1, 8'h40, 1'b1);
        n_checks++; if (imem_addr !== 8'h40) begin n_fail++; $display("FAIL jump_to_40: got %h want 40", imem_addr); end
        exec_instr(16'h3333, 1'b0, 1'b1, 8'hFF, 1'b1);
        n_checks++; if (imem_addr !== 8'hFF) begin n_fail++; $display("FAIL jump_to_ff: got %h want ff", imem_addr); end
        exec_instr(16'h4444, 1'b0, 1'b0, 8'h55, 1'b0);
        n_checks++; if ({pc, retired, busy} !== {8'h00, 16'd6, 1'b0})
            begin n_fail++; $display("FAIL jump_wrap: got pc=%h ret=%0d busy=%b want pc=00 ret=6 busy=0", pc, retired, busy); end
    endtask

    task automatic test_print_jump();
        run = 1'b1;
        step();
        n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL pj_addr: got %h want 00", imem_addr); end
        imem_valid = 1'b1; imem_data = 16'h00A5; dec_print = 1'b1;
        step();
        imem_valid = 1'b0; run = 1'b0;
        step();
        jump_taken = 1'b1; jump_target = 8'h30;
        step();
        jump_taken = 1'b0; jump_target = 8'h99;
        n_checks++; if ({pc, print_valid} !== {8'h00, 1'b1})
            begin n_fail++; $display("FAIL pj_hold: got pc=%h pv=%b want pc=00 pv=1", pc, print_valid); end
        print_ready = 1'b1;
        step();
        print_ready = 1'b0; dec_print = 1'b0; jump_target = 8'h00;
        n_checks++; if ({pc, retired} !== {8'h30, 16'd7})
            begin n_fail++; $display("FAIL pj_done: got pc=%h ret=%0d want pc=30 ret=7", pc, retired); end
    endtask

    task automatic test_mem_wait();
        int req_cnt = 0;
        int bad_addr = 0;
        run = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            if (imem_req === 1'b1) req_cnt++;
            if (imem_addr !== 8'h30) bad_addr++;
            n_checks++; if (instr_q !== 16'h00A5)
                begin n_fail++; $display("FAIL wait_instr_%0d: got %h want 00a5", i, instr_q); end
            step();
        end
        if (imem_req === 1'b1) req_cnt++;
        if (imem_addr !== 8'h30) bad_addr++;
        imem_valid = 1'b1; imem_data = 16'h3C01;
        step();
        n_checks++; if (req_cnt !== 4) begin n_fail++; $display("FAIL wait_req_cycles: got %0d want 4", req_cnt); end
        n_checks++; if (bad_addr !== 0) begin n_fail++; $display("FAIL wait_addr_stable: got %0d bad cycles want 0", bad_addr); end
        n_checks++; if ({imem_req, instr_q} !== {1'b0, 16'h3C01})
            begin n_fail++; $display("FAIL wait_latch: got req=%b instr=%h want 0 3c01", imem_req, instr_q); end
        imem_data = 16'hFFFF; run = 1'b0;
        step();
        imem_valid = 1'b0;
        n_checks++; if (instr_q !== 16'h3C01) begin n_fail++; $display("FAIL stray_valid: got %h want 3c01", instr_q); end
        step();
        n_checks++; if ({pc, retired} !== {8'h31, 16'd8})
            begin n_fail++; $display("FAIL wait_done: got pc=%h ret=%0d want pc=31 ret=8", pc, retired); end
    endtask

    task automatic test_run_drop();
        int req_cnt = 0;
        run = 1'b1;
        step();
        imem_valid = 1'b1; imem_data = 16'h0101; dec_reg_write = 1'b1;
        step();
        imem_valid = 1'b0; run = 1'b0;
        step();
        n_checks++; if ({rf_we, busy} !== 2'b11)
            begin n_fail++; $display("FAIL drop_exec: got we=%b busy=%b want 1 1", rf_we, busy); end
        step();
        dec_reg_write = 1'b0;
        n_checks++; if ({busy, pc, retired} !== {1'b0, 8'h32, 16'd9})
            begin n_fail++; $display("FAIL drop_idle: got busy=%b pc=%h ret=%0d want 0 32 9", busy, pc, retired); end
        for (int i = 0; i < 3; i++) begin
            if (imem_req !== 1'b0 || busy !== 1'b0) req_cnt++;
            step();
        end
        n_checks++; if (req_cnt !== 0) begin n_fail++; $display("FAIL drop_parked: got %0d active cycles want 0", req_cnt); end
        run = 1'b1;
        step();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 8'h32})
            begin n_fail++; $display("FAIL resume_addr: got req=%b addr=%h want 1 32", imem_req, imem_addr); end
        exec_instr(16'h0202, 1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++; if ({pc, retired} !== {8'h33, 16'd10})
            begin n_fail++; $display("FAIL resume_done: got pc=%h ret=%0d want pc=33 ret=10", pc, retired); end
    endtask

    task automatic test_reset_print();
        run = 1'b1;
        step();
        imem_valid = 1'b1; imem_data = 16'h0777; dec_print = 1'b1;
        step();
        imem_valid = 1'b0; run = 1'b0;
        step();
        step();
        n_checks++; if ({print_valid, busy} !== 2'b11)
            begin n_fail++; $display("FAIL rp_in_print: got pv=%b busy=%b want 1 1", print_valid, busy); end
        #3;
        reset = 1'b1; print_ready = 1'b1;
        #1;
        n_checks++; if ({print_valid, busy, imem_req} !== 3'b000)
            begin n_fail++; $display("FAIL rp_async: got pv=%b busy=%b req=%b want 0 0 0", print_valid, busy, imem_req); end
        n_checks++; if ({pc, retired, instr_q} !== {8'h00, 16'd0, 16'h0000})
            begin n_fail++; $display("FAIL rp_values: got pc=%h ret=%0d instr=%h want 00 0 0000", pc, retired, instr_q); end
        step();
        reset = 1'b0;
        step();
        print_ready = 1'b0; dec_print = 1'b0;
        n_checks++; if ({retired, print_valid, busy} !== {16'd0, 1'b0, 1'b0})
            begin n_fail++; $display("FAIL rp_no_handshake: got ret=%0d pv=%b busy=%b want 0 0 0", retired, print_valid, busy); end
    endtask

    task automatic test_back_to_back();
        run = 1'b1;
        step();
        exec_instr(16'h5A5A, 1'b1, 1'b0, 8'h00, 1'b1);
        n_checks++; if ({imem_req, imem_addr, retired} !== {1'b1, 8'h01, 16'd1})
            begin n_fail++; $display("FAIL b2b_first: got req=%b addr=%h ret=%0d want 1 01 1", imem_req, imem_addr, retired); end
        exec_instr(16'hA5A5, 1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++; if ({pc, retired, busy} !== {8'h02, 16'd2, 1'b0})
            begin n_fail++; $display("FAIL b2b_second: got pc=%h ret=%0d busy=%b want 02 2 0", pc, retired, busy); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_print();
        test_jump();
        test_print_jump();
        test_mem_wait();
        test_run_drop();
        test_reset_print();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
